dualrail_scan_driver: RTL and testbench
=======================================

Name: dualrail_scan_driver

Overview:
Clocked test and environment driver that sits directly upstream of the dual-rail four-phase scan flop and also consumes its output. It serialises an N-bit binary pattern into dual-rail codewords on one of two scan-flop inputs. Each bit goes through a full return-to-zero req/ack handshake, and the dual-rail q response is collected into a binary result word. It bridges the synchronous test/control domain to the self-timed scan-flop datapath.

Parameters:
N_BITS, 8, pattern/result length in bits (1..32)
TIMEOUT, 255, maximum clk cycles spent in any wait-for-ack state before error (1..65535)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  pulse: begin a sequence; ignored while busy
src_sel  input  1  0 = drive input 1 (in1 rails, sel0); 1 = drive input 2 (in2 rails, sel1)
pat  input  N_BITS  data bits, captured on start
pat_vld  input  N_BITS  per-bit: 1 = drive data; 0 = drive null (both rails 0, flop returns held state); captured on start
in1_0, in1_1, in2_0, in2_1  output  1 each  dual-rail data to scan flop
sel0, sel1  output  1 each  one-hot input select to scan flop
req  output  1  four-phase request
ack  input  1  four-phase acknowledge (asynchronous)
q0, q1  input  1 each  dual-rail scan-flop output (asynchronous)
result  output  N_BITS  result[i] = q1 sampled for bit i
busy  output  1  high from the cycle after start until done
done  output  1  one-cycle pulse at sequence end (normal or error)
to_err  output  1  sticky: ack timeout; cleared on next accepted start
enc_err  output  1  sticky: illegal q codeword at ack-high; cleared on next accepted start

Behaviour:
- Reset (async, rst_n=0): all outputs 0. State IDLE, bit index 0, synchronisers cleared. On rst_n deassertion, req=0 and all rails are at spacer.
- ack, q0, q1 pass through 2-flop synchronisers (ack_s, q0_s, q1_s). The FSM uses only the synchronised copies.
- States: IDLE, SETUP, REQ, WAIT_HI, REL, WAIT_LO, SPACER, DONE, ERR.
- IDLE: on start=1, capture pat, pat_vld and src_sel. Clear result, to_err and enc_err; set idx=0 and busy=1; go to SETUP.
- SETUP (1 cycle): drive the selected sel rail to 1 and the other to 0.
  - pat_vld[idx]=1 drives the x_1/x_0 rails of the selected input to pat[idx] / ~pat[idx].
  - pat_vld[idx]=0 drives both rails 0.
  - The unselected input's rails stay 0. Go to REQ.
- REQ: req=1 (data has been stable for ≥1 cycle). Go to WAIT_HI.
- WAIT_HI: wait for ack_s=1. On that cycle:
  - q0_s^q1_s=1: result[idx] = q1_s.
  - otherwise: set enc_err, result[idx]=0, continue.
  - Go to REL.
- REL: req=0; data and sel rails are held. Go to WAIT_LO.
- WAIT_LO: wait for ack_s=0 and q0_s=q1_s=0, then go to SPACER.
- SPACER (1 cycle): all data and sel rails 0.
  - If idx=N_BITS-1, go to DONE.
  - Otherwise idx++ and go to SETUP.
- DONE: done=1 for 1 cycle, busy=0, go to IDLE. result holds until the next accepted start.
- Timeout: a per-wait counter is cleared on entry to WAIT_HI or WAIT_LO. If it reaches TIMEOUT with the condition unmet, go to ERR.
- ERR (1 cycle): req=0, all rails 0, to_err=1, done=1, busy=0, go to IDLE. result keeps only the bits completed so far.
- Invariants, checked every cycle:
  - never both rails of one input high;
  - sel0 & sel1 = 0;
  - data and sel rails never change while req=1 or ack_s=1.
- start while busy: ignored, no capture.
- Reset mid-operation: immediate return to IDLE with all outputs 0. The downstream flop sees req fall and must complete its own reset phase. A new start must not be issued before ack_s=0; if it is, the first WAIT_HI sees ack_s=1 immediately and the resulting enc_err/result garbage is accepted behaviour.
- Timing: minimum cycles per bit = 8 with an instantly responding flop (SETUP, REQ, WAIT_HI≥2 for sync, REL, WAIT_LO≥2, SPACER).

Test Plan:
- N_BITS=8, src_sel=0, pat=0xA5, pat_vld=0xFF, model responds q=data after 3 clk, ack 1 clk later -> in1 rails follow pat bit 0 first, result=0xA5, done one pulse, no errors, in2/sel1 stay 0.
- src_sel=1, pat=0x0F, pat_vld=0xF0, model holds state (initially 0, updated by data bits) -> null bits 0-3 return 0, result=0x00; then pat=0xFF, pat_vld=0xFF followed by all-null run -> result=0xFF.
- ack tied 0, TIMEOUT=16 -> req high exactly 16 cycles in WAIT_HI, then ERR: to_err=1, done pulse, req=0, all rails 0, busy=0.
- Model returns q0=q1=1 on bit 3 -> enc_err=1, result[3]=0, sequence continues to done; next start clears enc_err.
- rst_n pulsed low during WAIT_HI of bit 2 -> outputs 0 asynchronously (same cycle), FSM in IDLE; after ack drops, start -> full correct sequence.
- start pulsed again while busy plus monitor assertions on rail exclusivity and data-stable-during-req -> second start ignored, zero assertion failures.

Source files
------------

// File: rtl/dualrail_scan_driver.sv
// Synchronous driver for a dual-rail four-phase scan flop: serialises a pattern through
// return-to-zero req/ack handshakes and gathers the dual-rail q responses into a word.
module dualrail_scan_driver #(
    parameter int N_BITS  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              src_sel,
    input  logic [N_BITS-1:0] pat,
    input  logic [N_BITS-1:0] pat_vld,
    output logic              in1_0,
    output logic              in1_1,
    output logic              in2_0,
    output logic              in2_1,
    output logic              sel0,
    output logic              sel1,
    output logic              req,
    input  logic              ack,
    input  logic              q0,
    input  logic              q1,
    output logic [N_BITS-1:0] result,
    output logic              busy,
    output logic              done,
    output logic              to_err,
    output logic              enc_err
);
    localparam int               IDX_W    = (N_BITS > 1) ? $clog2(N_BITS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_BITS - 1);
    localparam logic [15:0]      CNT_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        SETUP   = 4'd1,
        REQ     = 4'd2,
        WAIT_HI = 4'd3,
        REL     = 4'd4,
        WAIT_LO = 4'd5,
        SPACER  = 4'd6,
        DONE    = 4'd7,
        ERR     = 4'd8
    } state_t;

    // A dual-rail codeword is valid data only when exactly one rail is high.
    function automatic logic dr_legal(input logic r0, input logic r1);
        return r0 ^ r1;
    endfunction

    state_t            state_r, state_nxt_s;
    logic [IDX_W-1:0]  idx_r, idx_nxt_s;
    logic [15:0]       cnt_r, cnt_nxt_s;
    logic [N_BITS-1:0] pat_r, pat_nxt_s, vld_r, vld_nxt_s, result_nxt_s;
    logic              src_r, src_nxt_s, to_err_nxt_s, enc_err_nxt_s;
    logic [2:0]        sync1_r, sync2_r;
    logic              ack_s, q0_s, q1_s;
    logic              drive_s, bit_vld_s, bit_dat_s, rail1_s, rail0_s, busy_nxt_s, done_nxt_s;

    // Two-flop synchronisers for the self-timed ack and q rails.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 3'b000;
            sync2_r <= 3'b000;
        end else begin
            sync1_r <= {ack, q1, q0};
            sync2_r <= sync1_r;
        end
    end

    assign {ack_s, q1_s, q0_s} = sync2_r;

    // Next-state, capture, result and error computation; outputs decode the next state.
    always_comb begin
        state_nxt_s   = state_r;
        idx_nxt_s     = idx_r;
        cnt_nxt_s     = cnt_r;
        pat_nxt_s     = pat_r;
        vld_nxt_s     = vld_r;
        src_nxt_s     = src_r;
        result_nxt_s  = result;
        to_err_nxt_s  = to_err;
        enc_err_nxt_s = enc_err;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s   = SETUP;
                    pat_nxt_s     = pat;
                    vld_nxt_s     = pat_vld;
                    src_nxt_s     = src_sel;
                    idx_nxt_s     = '0;
                    result_nxt_s  = '0;
                    to_err_nxt_s  = 1'b0;
                    enc_err_nxt_s = 1'b0;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SETUP: state_nxt_s = REQ;
            REQ: begin
                state_nxt_s = WAIT_HI;
                cnt_nxt_s   = 16'd0;
            end
            WAIT_HI: begin
                if (ack_s) begin
                    state_nxt_s = REL;
                    if (dr_legal(q0_s, q1_s)) begin
                        result_nxt_s[idx_r] = q1_s;
                    end else begin
                        result_nxt_s[idx_r] = 1'b0;
                        enc_err_nxt_s       = 1'b1;
                    end
                end else if (cnt_r == CNT_LAST) begin
                    state_nxt_s  = ERR;
                    to_err_nxt_s = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r + 16'd1;
                end
            end
            REL: begin
                state_nxt_s = WAIT_LO;
                cnt_nxt_s   = 16'd0;
            end
            WAIT_LO: begin
                if (!ack_s && !q0_s && !q1_s) begin
                    state_nxt_s = SPACER;
                end else if (cnt_r == CNT_LAST) begin
                    state_nxt_s  = ERR;
                    to_err_nxt_s = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r + 16'd1;
                end
            end
            SPACER: begin
                if (idx_r == IDX_LAST) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = SETUP;
                    idx_nxt_s   = idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
                end
            end
            DONE:    state_nxt_s = IDLE;
            ERR:     state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase

        drive_s    = state_nxt_s inside {SETUP, REQ, WAIT_HI, REL, WAIT_LO};
        busy_nxt_s = state_nxt_s inside {SETUP, REQ, WAIT_HI, REL, WAIT_LO, SPACER};
        done_nxt_s = state_nxt_s inside {DONE, ERR};
        bit_vld_s  = vld_nxt_s[idx_nxt_s];
        bit_dat_s  = pat_nxt_s[idx_nxt_s];
        rail1_s    = drive_s & bit_vld_s & bit_dat_s;
        rail0_s    = drive_s & bit_vld_s & ~bit_dat_s;
    end

    // State, captured pattern and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            idx_r   <= '0;
            cnt_r   <= 16'd0;
            pat_r   <= '0;
            vld_r   <= '0;
            src_r   <= 1'b0;
            in1_0   <= 1'b0;
            in1_1   <= 1'b0;
            in2_0   <= 1'b0;
            in2_1   <= 1'b0;
            sel0    <= 1'b0;
            sel1    <= 1'b0;
            req     <= 1'b0;
            result  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            to_err  <= 1'b0;
            enc_err <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            idx_r   <= idx_nxt_s;
            cnt_r   <= cnt_nxt_s;
            pat_r   <= pat_nxt_s;
            vld_r   <= vld_nxt_s;
            src_r   <= src_nxt_s;
            in1_0   <= rail0_s & ~src_nxt_s;
            in1_1   <= rail1_s & ~src_nxt_s;
            in2_0   <= rail0_s & src_nxt_s;
            in2_1   <= rail1_s & src_nxt_s;
            sel0    <= drive_s & ~src_nxt_s;
            sel1    <= drive_s & src_nxt_s;
            req     <= (state_nxt_s == REQ) || (state_nxt_s == WAIT_HI);
            result  <= result_nxt_s;
            busy    <= busy_nxt_s;
            done    <= done_nxt_s;
            to_err  <= to_err_nxt_s;
            enc_err <= enc_err_nxt_s;
        end
    end
endmodule

// File: tb/tb_dualrail_scan_driver.sv
// Scoreboard bench for dualrail_scan_driver: a behavioural scan-flop model answers the
// handshakes, a reference predicts each sequence outcome, and a monitor checks done events.
module tb_dualrail_scan_driver;
    localparam int NB = 8;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst_n, start, src_sel, ack, q0, q1;
    logic [NB-1:0] pat, pat_vld, result;
    logic in1_0, in1_1, in2_0, in2_1, sel0, sel1, req, busy, done, to_err, enc_err;

    typedef struct packed {
        logic [NB-1:0] res;
        logic          to;
        logic          enc;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0, n_fail = 0, n_pushed = 0, n_done = 0;
    int   m_ph = 0, m_cnt = 0, m_bit = 0, bad_idx = -1, q_dly = 3;
    logic tie_ack0 = 1'b0, held = 1'b0, ref_held = 1'b0, cur_src = 1'b0;

    dualrail_scan_driver #(.N_BITS(NB), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .src_sel(src_sel),
        .pat(pat), .pat_vld(pat_vld),
        .in1_0(in1_0), .in1_1(in1_1), .in2_0(in2_0), .in2_1(in2_1),
        .sel0(sel0), .sel1(sel1), .req(req), .ack(ack), .q0(q0), .q1(q1),
        .result(result), .busy(busy), .done(done), .to_err(to_err), .enc_err(enc_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    // Spec-level prediction: a null bit returns the flop's held state, a data bit
    // becomes the new held state, and an illegal codeword reads back as 0 with enc_err.
    function automatic exp_t ref_run(input logic [NB-1:0] p, input logic [NB-1:0] v, input int bad);
        exp_t e;
        e.res = '0;
        e.to  = 1'b0;
        e.enc = 1'b0;
        for (int i = 0; i < NB; i++) begin
            if (i == bad) begin
                e.enc = 1'b1;
            end else begin
                if (v[i]) ref_held = p[i];
                e.res[i] = ref_held;
            end
        end
        return e;
    endfunction

    // Behavioural scan flop: q appears q_dly cycles after req rises, ack one cycle later.
    initial begin
        ack = 1'b0; q0 = 1'b0; q1 = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (m_ph)
                0: if (req === 1'b1 && !tie_ack0) begin m_cnt = q_dly; m_ph = 1; end
                1: begin
                    if (m_cnt > 1) begin
                        m_cnt--;
                    end else begin
                        if (m_bit == bad_idx) begin
                            q0 = 1'b1; q1 = 1'b1;
                        end else begin
                            if (sel0 ? (in1_0 | in1_1) : (in2_0 | in2_1)) held = sel0 ? in1_1 : in2_1;
                            q1 = held; q0 = ~held;
                        end
                        m_ph = 2;
                    end
                end
                2: begin ack = 1'b1; m_ph = 3; end
                3: if (req !== 1'b1) begin q0 = 1'b0; q1 = 1'b0; m_ph = 4; end
                4: begin ack = 1'b0; m_bit++; m_ph = 0; end
                default: m_ph = 0;
            endcase
        end
    end

    // Monitor: pops the scoreboard on every done and checks rail invariants each cycle.
    initial begin
        logic prev_done, prev_req, prev_ack, prev_rst;
        logic [5:0] prev_rails, rails;
        exp_t e;
        prev_done = 1'b0; prev_req = 1'b0; prev_ack = 1'b0; prev_rst = 1'b0; prev_rails = '0;
        forever begin
            @(negedge clk);
            rails = {in1_0, in1_1, in2_0, in2_1, sel0, sel1};
            if (rst_n === 1'b1 && prev_rst) begin
                if (done === 1'b1) begin
                    n_done++;
                    chk("done_single_pulse", {31'd0, prev_done}, 32'd0);
                    if (exp_q.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL unexpected_done: got done with empty scoreboard, expected none");
                    end else begin
                        e = exp_q.pop_front();
                        chk("result", {24'd0, result}, {24'd0, e.res});
                        chk("to_err", {31'd0, to_err}, {31'd0, e.to});
                        chk("enc_err", {31'd0, enc_err}, {31'd0, e.enc});
                        chk("busy_at_done", {31'd0, busy}, 32'd0);
                    end
                end
                chk("rail_exclusive", {29'd0, in1_0 & in1_1, in2_0 & in2_1, sel0 & sel1}, 32'd0);
                chk("unselected_quiet", {29'd0, cur_src ? {in1_0, in1_1, sel0} : {in2_0, in2_1, sel1}}, 32'd0);
                if ((prev_req || prev_ack) && !(done && to_err))
                    chk("stable_during_handshake", {26'd0, rails}, {26'd0, prev_rails});
            end
            prev_done = done; prev_req = req; prev_ack = ack; prev_rails = rails; prev_rst = rst_n;
        end
    end

    task automatic wait_idle();
        int c;
        c = 0;
        repeat (2) @(negedge clk);
        while ((busy || done || ack || m_ph != 0) && c < 200) begin @(negedge clk); c++; end
        if (c >= 200) begin
            n_chk++; n_fail++;
            $display("FAIL wait_idle: busy=%0b ack=%0b still active, expected idle within 200 cycles", busy, ack);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_done(input int budget);
        int c;
        c = 0;
        while (done !== 1'b1 && c < budget) begin @(negedge clk); c++; end
        if (done !== 1'b1) begin
            n_chk++; n_fail++;
            $display("FAIL wait_done: done=%0b after %0d cycles, expected 1", done, budget);
        end
    endtask

    task automatic issue_start(input logic [NB-1:0] p, input logic [NB-1:0] v, input logic s);
        pat = p; pat_vld = v; src_sel = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        chk("to_err_cleared", {31'd0, to_err}, 32'd0);
        chk("enc_err_cleared", {31'd0, enc_err}, 32'd0);
        chk("result_cleared", {24'd0, result}, 32'd0);
    endtask

    task automatic run_seq(input logic [NB-1:0] p, input logic [NB-1:0] v, input logic s,
                           input int bad, input logic chk_first, input logic dbl);
        int c;
        wait_idle();
        bad_idx = bad; m_bit = 0; cur_src = s;
        exp_q.push_back(ref_run(p, v, bad));
        n_pushed++;
        issue_start(p, v, s);
        if (chk_first) begin
            c = 0;
            while (!(sel0 || sel1) && c < 10) begin @(negedge clk); c++; end
            chk("first_bit_rails", {30'd0, s ? {in2_1, in2_0} : {in1_1, in1_0}},
                {30'd0, p[0] & v[0], ~p[0] & v[0]});
        end
        if (dbl) begin
            repeat (4) @(negedge clk);
            pat = ~p; pat_vld = ~v; src_sel = ~s; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            chk("busy_ignored_start", {31'd0, busy}, 32'd1);
        end
        wait_done(400);
    endtask

    task automatic run_timeout();
        exp_t e;
        int reqs, c;
        wait_idle();
        tie_ack0 = 1'b1; bad_idx = -1; m_bit = 0; cur_src = 1'b0;
        e.res = '0; e.to = 1'b1; e.enc = 1'b0;
        exp_q.push_back(e);
        n_pushed++;
        issue_start(8'h5A, 8'hFF, 1'b0);
        reqs = 0; c = 0;
        while (done !== 1'b1 && c < 400) begin
            if (req) reqs++;
            @(negedge clk);
            c++;
        end
        // one REQ cycle plus TO cycles waiting in WAIT_HI
        chk("timeout_req_cycles", reqs, TO + 1);
        chk("err_outputs_quiet", {24'd0, in1_0, in1_1, in2_0, in2_1, sel0, sel1, req, busy}, 32'd0);
        wait_idle();
        tie_ack0 = 1'b0;
        chk("to_err_sticky", {31'd0, to_err}, 32'd1);
    endtask

    task automatic run_reset_mid();
        int c;
        wait_idle();
        bad_idx = -1; m_bit = 0; cur_src = 1'b0; q_dly = 3;
        issue_start(8'h3C, 8'hFF, 1'b0);
        c = 0;
        while (!(m_bit == 2 && req === 1'b1) && c < 300) begin @(negedge clk); c++; end
        chk("reached_bit2_req", {31'd0, req}, 32'd1);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {21'd0, in1_0, in1_1, in2_0, in2_1, sel0, sel1, req, busy, done, to_err, enc_err}, 32'd0);
        chk("async_reset_result", {24'd0, result}, 32'd0);
        repeat (2) @(negedge clk);
        c = 0;
        while ((ack !== 1'b0 || m_ph != 0) && c < 100) begin @(negedge clk); c++; end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_after_reset", {30'd0, busy, done}, 32'd0);
        run_seq(8'($urandom), 8'hFF, 1'b0, -1, 1'b0, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at 500000, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; src_sel = 1'b0; pat = '0; pat_vld = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {21'd0, in1_0, in1_1, in2_0, in2_1, sel0, sel1, req, busy, done, to_err, enc_err}, 32'd0);
        chk("reset_result", {24'd0, result}, 32'd0);
        rst_n = 1'b1;

        // null bits return the flop's initial held state of 0
        run_seq(8'h0F, 8'hF0, 1'b1, -1, 1'b1, 1'b0);
        run_seq(8'hFF, 8'hFF, 1'b1, -1, 1'b0, 1'b0);
        run_seq(8'h00, 8'h00, 1'b1, -1, 1'b0, 1'b0);
        run_seq(8'hA5, 8'hFF, 1'b0, -1, 1'b1, 1'b0);
        run_seq(8'h6B, 8'hFF, 1'b0, 3, 1'b0, 1'b0);
        wait_idle();
        chk("enc_err_sticky", {31'd0, enc_err}, 32'd1);
        run_seq(8'h93, 8'hFF, 1'b0, -1, 1'b0, 1'b0);
        run_timeout();
        run_seq(8'h2D, 8'hFF, 1'b0, -1, 1'b0, 1'b0);
        run_seq(8'hC6, 8'h7E, 1'b1, -1, 1'b0, 1'b1);
        run_reset_mid();
        for (int r = 0; r < 12; r++) begin
            q_dly = $urandom_range(1, 4);
            run_seq(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NB - 1)) : -1,
                    1'b1, 1'($urandom_range(0, 1)));
        end
        wait_idle();
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        chk("done_count", n_done, n_pushed);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
